// File: rtl/unwhiten.sv
// Rebuilds sensor-space data from PCA components: X[i][k] = sat(round(sum_j V[j][i]*U[j][k] >> FRAC) + mean[i]).
// Latency: f rises 1+SIZE_A*SIZE_B*(SIZE_A+1) edges after start is sampled; one shared multiplier.
// Backpressure: none; start is ignored while busy, and mat_out is held in DONE until the next start.
module unwhiten #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 32,
    parameter int W_IN   = 35,
    parameter int W_COEF = 18,
    parameter int FRAC   = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [SIZE_A-1:0][SIZE_B-1:0][W_IN-1:0]       mat,
    input  logic [SIZE_A-1:0][SIZE_A-1:0][W_COEF-1:0]     eigvec,
    input  logic [SIZE_A-1:0][N_BITS-1:0]                 mean,
    output logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0]     mat_out,
    output logic                                          busy,
    output logic                                          f
);

    localparam int IW     = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int KW     = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam int W_PROD = W_IN + W_COEF;
    localparam int W_ACC  = W_PROD + $clog2(SIZE_A) + 1;
    localparam int W_EXT  = W_ACC + 1;

    localparam logic [IW-1:0] A_LAST = IW'(SIZE_A - 1);
    localparam logic [KW-1:0] B_LAST = KW'(SIZE_B - 1);

    localparam logic signed [W_EXT-1:0] HALF   = W_EXT'(1) << (FRAC - 1);
    localparam logic signed [W_EXT-1:0] SAT_HI = (W_EXT'(1) << (N_BITS - 1)) - W_EXT'(1);
    localparam logic signed [W_EXT-1:0] SAT_LO = -(W_EXT'(1) << (N_BITS - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SIZE_A-1:0][SIZE_B-1:0][W_IN-1:0]   u_q, u_d;
    logic [SIZE_A-1:0][SIZE_A-1:0][W_COEF-1:0] v_q, v_d;
    logic [SIZE_A-1:0][N_BITS-1:0]             mean_q, mean_d;
    logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0] out_q, out_d;
    logic signed [W_ACC-1:0]                   acc_q, acc_d;
    logic [IW-1:0]                             i_q, i_d;
    logic [IW-1:0]                             j_q, j_d;
    logic [KW-1:0]                             k_q, k_d;

    logic signed [W_COEF-1:0] coef;
    logic signed [W_IN-1:0]   comp;
    logic signed [W_PROD-1:0] prod;
    logic signed [W_EXT-1:0]  rnd;
    logic signed [W_EXT-1:0]  shr;
    logic signed [W_EXT-1:0]  sum_s;
    logic [N_BITS-1:0]        sat_val;

    // Datapath: the single multiplier and the round/offset/saturate chain.
    always_comb begin
        coef  = signed'(v_q[j_q][i_q]);
        comp  = signed'(u_q[j_q][k_q]);
        prod  = W_PROD'(coef) * W_PROD'(comp);
        rnd   = W_EXT'(acc_q) + HALF;
        shr   = rnd >>> FRAC;
        sum_s = shr + W_EXT'(signed'(mean_q[i_q]));
        if (sum_s > SAT_HI) begin
            sat_val = SAT_HI[N_BITS-1:0];
        end else if (sum_s < SAT_LO) begin
            sat_val = SAT_LO[N_BITS-1:0];
        end else begin
            sat_val = sum_s[N_BITS-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        mean_d  = mean_q;
        out_d   = out_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                u_d     = mat;
                v_d     = eigvec;
                mean_d  = mean;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                acc_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + W_ACC'(prod);
                if (j_q == A_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_WRITE: begin
                out_d[i_q][k_q] = sat_val;
                acc_d           = '0;
                j_d             = '0;
                state_d         = S_MAC;
                if (k_q == B_LAST) begin
                    k_d = '0;
                    if (i_q == A_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            mean_q  <= '0;
            out_q   <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            mean_q  <= mean_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    assign mat_out = out_q;
    assign busy    = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_WRITE);
    assign f       = (state_q == S_DONE);

endmodule

// File: tb/tb_unwhiten.sv
// Scoreboard bench for unwhiten: expected matrices are queued at stimulus time and drained once f rises.
module tb_unwhiten;

    localparam int SA = 8;
    localparam int SB = 8;
    localparam int NB = 32;
    localparam int WI = 35;
    localparam int WC = 18;
    localparam int FR = 16;
    localparam int LAT = 1 + SA * SB * (SA + 1);

    logic                            clk;
    logic                            rst;
    logic                            start;
    logic [SA-1:0][SB-1:0][WI-1:0]   mat;
    logic [SA-1:0][SA-1:0][WC-1:0]   eigvec;
    logic [SA-1:0][NB-1:0]           mean;
    logic [SA-1:0][SB-1:0][NB-1:0]   mat_out;
    logic                            busy;
    logic                            f;

    int total = 0;
    int bad   = 0;
    logic [NB-1:0] exp_q[$];

    unwhiten #(
        .SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB), .W_IN(WI), .W_COEF(WC), .FRAC(FR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mat(mat), .eigvec(eigvec),
        .mean(mean), .mat_out(mat_out), .busy(busy), .f(f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model evaluated on the current inputs, widened to 64 bits.
    function automatic void push_expected();
        for (int i = 0; i < SA; i++) begin
            for (int k = 0; k < SB; k++) begin
                longint acc = 0;
                longint s;
                for (int j = 0; j < SA; j++) begin
                    acc += longint'($signed(eigvec[j][i])) * longint'($signed(mat[j][k]));
                end
                s = ((acc + (64'sd1 <<< (FR - 1))) >>> FR) + longint'($signed(mean[i]));
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
                exp_q.push_back(s[NB-1:0]);
            end
        end
    endfunction

    task automatic set_diag(input int val);
        eigvec = '0;
        for (int j = 0; j < SA; j++) eigvec[j][j] = WC'(val);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++)
                mat[i][k] = WI'(i * 8 + k - 20);
    endtask

    // Pulses start, then waits (bounded) for f; optional extra start pulses at given edges.
    task automatic run_op(input int pa, input int pb, output int edges, output int bcnt);
        edges = 0;
        bcnt  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (busy) bcnt++;
        while (edges < 2000) begin
            @(posedge clk);
            edges++;
            #1;
            start = (edges == pa) || (edges == pb);
            if (f) break;
            if (busy) bcnt++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; mat = '0; eigvec = '0; mean = '0;
        #12;
        total++;
        if (mat_out !== '0) begin bad++; $display("FAIL reset_mat_out got %h want 0", mat_out[0][0]); end
        total++;
        if (busy !== 1'b0 || f !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%b f=%b want 0 0", busy, f); end
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || f !== 1'b0) begin bad++; $display("FAIL idle_no_start got busy=%b f=%b want 0 0", busy, f); end
    endtask

    task automatic test_identity();
        int edges, bcnt;
        set_diag(65536); mean = '0; set_ramp();
        push_expected();
        run_op(0, 0, edges, bcnt);
        total++;
        if (edges !== LAT) begin bad++; $display("FAIL ident_latency got %0d want %0d", edges, LAT); end
        total++;
        if (bcnt !== LAT) begin bad++; $display("FAIL ident_busy_cycles got %0d want %0d", bcnt, LAT); end
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e) begin
                    bad++; $display("FAIL ident[%0d][%0d] got %0d want %0d", i, k, $signed(mat_out[i][k]), $signed(e));
                end
            end
        total++;
        if ($signed(mat_out[0][0]) !== -32'sd20) begin bad++; $display("FAIL ident_corner got %0d want -20", $signed(mat_out[0][0])); end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (f !== 1'b1 || $signed(mat_out[7][7]) !== 32'sd43) begin
            bad++; $display("FAIL done_hold got f=%b x77=%0d want 1 43", f, $signed(mat_out[7][7]));
        end
    endtask

    task automatic test_mean_sat();
        int edges, bcnt;
        set_diag(65536); set_ramp();
        for (int i = 0; i < SA; i++) mean[i] = NB'(100 * i - 350);
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        total++;
        if (f !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rerun_f_drop got f=%b busy=%b want 0 1", f, busy); end
        edges = 0;
        while (edges < 2000 && !f) begin @(posedge clk); edges++; #1; end
        total++;
        if (edges + 0 !== LAT) begin bad++; $display("FAIL mean_latency got %0d want %0d", edges, LAT); end
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e) begin
                    bad++; $display("FAIL mean[%0d][%0d] got %0d want %0d", i, k, $signed(mat_out[i][k]), $signed(e));
                end
            end
        // Positive saturation: max mean plus positive components; negative: min mean plus negative.
        for (int i = 0; i < SA; i++) begin
            mean[i] = (i < 4) ? 32'h7fffffff : 32'h80000000;
            for (int k = 0; k < SB; k++) mat[i][k] = (i < 4) ? WI'(k + 1) : WI'(-(k + 1));
        end
        push_expected();
        run_op(0, 0, edges, bcnt);
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e || mat_out[i][k] !== ((i < 4) ? 32'h7fffffff : 32'h80000000)) begin
                    bad++; $display("FAIL sat[%0d][%0d] got %h want %h", i, k, mat_out[i][k], e);
                end
            end
    endtask

    task automatic test_round();
        int edges, bcnt;
        set_diag(32768); mean = '0;
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++)
                mat[i][k] = (k % 3 == 0) ? WI'(3) : (k % 3 == 1) ? WI'(-3) : WI'(-4 - i);
        push_expected();
        run_op(0, 0, edges, bcnt);
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e) begin
                    bad++; $display("FAIL round[%0d][%0d] got %0d want %0d", i, k, $signed(mat_out[i][k]), $signed(e));
                end
            end
        total++;
        if ($signed(mat_out[0][0]) !== 32'sd2 || $signed(mat_out[0][1]) !== -32'sd1 || $signed(mat_out[0][2]) !== -32'sd2) begin
            bad++; $display("FAIL round_half got %0d %0d %0d want 2 -1 -2",
                $signed(mat_out[0][0]), $signed(mat_out[0][1]), $signed(mat_out[0][2]));
        end
    endtask

    task automatic test_perm();
        int edges, bcnt;
        eigvec = '0; mean = '0; set_ramp();
        for (int j = 0; j < SA; j++) eigvec[j][(j + 1) % SA] = WC'(65536);
        push_expected();
        run_op(0, 0, edges, bcnt);
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e || $signed(mat_out[i][k]) !== ((i + 7) % 8) * 8 + k - 20) begin
                    bad++; $display("FAIL perm[%0d][%0d] got %0d want %0d", i, k, $signed(mat_out[i][k]), $signed(e));
                end
            end
        // Full-magnitude negative components against -1.0 everywhere drive the sum far above max.
        for (int j = 0; j < SA; j++) begin
            for (int i = 0; i < SA; i++) eigvec[j][i] = WC'(-65536);
            for (int k = 0; k < SB; k++) mat[j][k] = {1'b1, {(WI - 1){1'b0}}};
        end
        push_expected();
        run_op(0, 0, edges, bcnt);
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e || mat_out[i][k] !== 32'h7fffffff) begin
                    bad++; $display("FAIL bigsat[%0d][%0d] got %h want %h", i, k, mat_out[i][k], e);
                end
            end
    endtask

    task automatic test_start_ignored();
        int edges, bcnt;
        set_diag(65536); set_ramp();
        for (int i = 0; i < SA; i++) mean[i] = NB'(i * 7 - 11);
        push_expected();
        run_op(100, 300, edges, bcnt);
        total++;
        if (edges !== LAT) begin bad++; $display("FAIL ignore_latency got %0d want %0d", edges, LAT); end
        total++;
        if (bcnt !== LAT) begin bad++; $display("FAIL ignore_busy got %0d want %0d", bcnt, LAT); end
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e) begin
                    bad++; $display("FAIL ignore[%0d][%0d] got %0d want %0d", i, k, $signed(mat_out[i][k]), $signed(e));
                end
            end
    endtask

    task automatic test_reset_mid();
        int edges, bcnt;
        eigvec = '0; mean = '0;
        for (int j = 0; j < SA; j++) eigvec[j][(j + 3) % SA] = WC'(-65536);
        set_ramp();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || mat_out === '0) begin bad++; $display("FAIL pre_abort got busy=%b want 1 with partial data", busy); end
        rst = 1'b0;
        #1;
        total++;
        if (mat_out !== '0) begin bad++; $display("FAIL abort_mat_out got %h want 0", mat_out[0][0]); end
        total++;
        if (busy !== 1'b0 || f !== 1'b0) begin bad++; $display("FAIL abort_flags got busy=%b f=%b want 0 0", busy, f); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || f !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b f=%b want 0 0", busy, f); end
        push_expected();
        run_op(0, 0, edges, bcnt);
        total++;
        if (edges !== LAT) begin bad++; $display("FAIL rerun_latency got %0d want %0d", edges, LAT); end
        for (int i = 0; i < SA; i++)
            for (int k = 0; k < SB; k++) begin
                logic [NB-1:0] e = exp_q.pop_front();
                total++;
                if (mat_out[i][k] !== e) begin
                    bad++; $display("FAIL rerun[%0d][%0d] got %0d want %0d", i, k, $signed(mat_out[i][k]), $signed(e));
                end
            end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_mean_sat();
        test_round();
        test_perm();
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
